// File: rtl/store_monitor.sv
// Pass/fail monitor on the CPU data-store port: classifies stores, detects
// timeout, and keeps a circular trace of the most recent stores.
module store_monitor #(
  parameter logic [31:0] PASS_ADR    = 32'd84,
  parameter logic [31:0] PASS_DATA   = 32'd7,
  parameter logic [31:0] OK_LO       = 32'd80,
  parameter logic [31:0] OK_HI       = 32'd80,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CW          = 16,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [CW-1:0] wr_count,
  output logic [31:0]   bad_adr,
  output logic [31:0]   bad_data,
  input  logic [AW-1:0] trace_idx,
  output logic          trace_valid,
  output logic [31:0]   trace_adr,
  output logic [31:0]   trace_data
);

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

  state_t        state;
  state_t        state_next;
  logic          accept;
  logic          capture;
  logic          cyc_last;
  logic [CW-1:0] cyc;
  logic [AW-1:0] wptr;
  logic [AW:0]   fill;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   trace_adr_mem  [DEPTH];
  logic [31:0]   trace_data_mem [DEPTH];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Store classification and timeout decision; terminal states hold
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    cyc_last   = (cyc == CW'(TIMEOUT_CYC - 1));
    if (state == ST_RUN) begin
      if (memwrite) begin
        accept = 1'b1;
        if (dataadr == PASS_ADR && writedata == PASS_DATA) begin
          state_next = ST_PASS;
        end else if (dataadr == PASS_ADR) begin
          state_next = ST_FAIL;
          capture    = 1'b1;
        end else if (dataadr < OK_LO || dataadr > OK_HI) begin
          state_next = ST_FAIL;
          capture    = 1'b1;
        end else if (cyc_last) begin
          state_next = ST_TIMEOUT;
        end
      end else if (cyc_last) begin
        state_next = ST_TIMEOUT;
      end
    end
  end

  // Counters, trace bookkeeping, failure capture and registered flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc      <= '0;
      wr_count <= '0;
      wptr     <= '0;
      fill     <= '0;
      bad_adr  <= '0;
      bad_data <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (state == ST_RUN) cyc <= cyc + CW'(1);
      if (accept) begin
        if (wr_count != '1) wr_count <= wr_count + CW'(1);
        wptr <= wptr + AW'(1);
        if (fill != (AW+1)'(DEPTH)) fill <= fill + (AW+1)'(1);
      end
      if (capture) begin
        bad_adr  <= dataadr;
        bad_data <= writedata;
      end
      done    <= (state_next != ST_RUN);
      pass    <= (state_next == ST_PASS);
      fail    <= (state_next == ST_FAIL);
      timeout <= (state_next == ST_TIMEOUT);
    end
  end

  // Trace storage; contents survive reset, validity comes from fill
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      trace_adr_mem[wptr]  <= dataadr;
      trace_data_mem[wptr] <= writedata;
    end
  end

  // Combinational trace read, newest entry at index 0
  always_comb begin
    rd_ptr      = wptr - AW'(1) - trace_idx;
    trace_valid = ({1'b0, trace_idx} < fill);
    trace_adr   = trace_valid ? trace_adr_mem[rd_ptr]  : 32'd0;
    trace_data  = trace_valid ? trace_data_mem[rd_ptr] : 32'd0;
  end

endmodule

// File: tb/tb_store_monitor.sv
// Self-checking bench for store_monitor: directed scenarios plus randomized
// stores compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_store_monitor;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned TO    = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          memwrite = 1'b0;
  logic [31:0]   dataadr = '0;
  logic [31:0]   writedata = '0;
  logic          done, pass, fail, timeout;
  logic [15:0]   wr_count;
  logic [31:0]   bad_adr, bad_data;
  logic [AW-1:0] trace_idx = '0;
  logic          trace_valid;
  logic [31:0]   trace_adr, trace_data;

  always #20 clk = ~clk;

  store_monitor #(.TIMEOUT_CYC(TO), .DEPTH(DEPTH), .CW(16)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .wr_count(wr_count), .bad_adr(bad_adr),
    .bad_data(bad_data), .trace_idx(trace_idx), .trace_valid(trace_valid),
    .trace_adr(trace_adr), .trace_data(trace_data)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: outcome, counts and a newest-first store history
  typedef enum {M_RUN, M_PASS, M_FAIL, M_TO} mstate_t;
  mstate_t     ms = M_RUN;
  int unsigned m_cnt = 0;
  int unsigned m_cyc = 0;
  logic [31:0] m_bad_adr = '0;
  logic [31:0] m_bad_data = '0;
  logic [31:0] q_adr[$];
  logic [31:0] q_data[$];

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(logic r, logic mw, logic [31:0] a, logic [31:0] d);
    if (r) begin
      ms = M_RUN; m_cnt = 0; m_cyc = 0; m_bad_adr = '0; m_bad_data = '0;
      q_adr.delete(); q_data.delete();
    end else if (ms == M_RUN) begin
      m_cyc++;
      if (mw) begin
        if (m_cnt < 65535) m_cnt++;
        q_adr.push_front(a); q_data.push_front(d);
        if (q_adr.size() > DEPTH) begin
          void'(q_adr.pop_back()); void'(q_data.pop_back());
        end
        if (a == 84 && d == 7) ms = M_PASS;
        else if (a != 80) begin
          ms = M_FAIL; m_bad_adr = a; m_bad_data = d;
        end else if (m_cyc == TO) ms = M_TO;
      end else if (m_cyc == TO) ms = M_TO;
    end
  endtask

  // Compare every output and every trace slot against the model
  task automatic check_all();
    cmp("done",     32'(done),     32'(ms != M_RUN));
    cmp("pass",     32'(pass),     32'(ms == M_PASS));
    cmp("fail",     32'(fail),     32'(ms == M_FAIL));
    cmp("timeout",  32'(timeout),  32'(ms == M_TO));
    cmp("wr_count", 32'(wr_count), m_cnt);
    cmp("bad_adr",  bad_adr,       m_bad_adr);
    cmp("bad_data", bad_data,      m_bad_data);
    for (int i = 0; i < DEPTH; i++) begin
      trace_idx = AW'(i);
      #1;
      cmp("trace_valid", 32'(trace_valid), 32'(i < q_adr.size()));
      cmp("trace_adr",  trace_adr,  (i < q_adr.size()) ? q_adr[i]  : 32'd0);
      cmp("trace_data", trace_data, (i < q_adr.size()) ? q_data[i] : 32'd0);
    end
  endtask

  task automatic step(logic r, logic mw, logic [31:0] a, logic [31:0] d);
    reset = r; memwrite = mw; dataadr = a; writedata = d;
    @(posedge clk);
    model_update(r, mw, a, d);
    #1;
    check_all();
  endtask

  task automatic sel(int idx);
    trace_idx = AW'(idx);
    #1;
  endtask

  initial begin
    int term_cycles;
    logic r, mw;
    logic [31:0] a, d;

    // Pass sequence
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 80, 3); step(0, 1, 84, 7);
    cmp("t1_pass", 32'(pass), 1); cmp("t1_done", 32'(done), 1);
    cmp("t1_count", 32'(wr_count), 2);
    sel(0); cmp("t1_tr0_adr", trace_adr, 84); cmp("t1_tr0_data", trace_data, 7);

    // Wrong data at pass address, then stores ignored
    step(1, 0, 0, 0); step(0, 1, 84, 6);
    cmp("t2_fail", 32'(fail), 1); cmp("t2_bad_adr", bad_adr, 84); cmp("t2_bad_data", bad_data, 6);
    step(0, 1, 80, 2); step(0, 1, 84, 7);
    cmp("t2_count", 32'(wr_count), 1); cmp("t2_pass", 32'(pass), 0);

    // Out-of-range store
    step(1, 0, 0, 0); step(0, 1, 80, 1); step(0, 1, 96, 5);
    cmp("t3_fail", 32'(fail), 1); cmp("t3_bad_adr", bad_adr, 96);
    sel(1); cmp("t3_tr1_adr", trace_adr, 80); cmp("t3_tr1_data", trace_data, 1);
    sel(2); cmp("t3_tr2_valid", 32'(trace_valid), 0);

    // Timeout on the 20th edge, and a pass store winning on that edge
    step(1, 0, 0, 0);
    repeat (TO - 1) step(0, 0, 0, 0);
    cmp("t4_timeout_early", 32'(timeout), 0);
    step(0, 0, 0, 0);
    cmp("t4_timeout", 32'(timeout), 1); cmp("t4_done", 32'(done), 1);
    step(1, 0, 0, 0);
    repeat (TO - 1) step(0, 0, 0, 0);
    step(0, 1, 84, 7);
    cmp("t4b_pass", 32'(pass), 1); cmp("t4b_timeout", 32'(timeout), 0);

    // Trace wrap
    step(1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) step(0, 1, 80, i);
    sel(0); cmp("t5_tr0_data", trace_data, 10);
    sel(7); cmp("t5_tr7_data", trace_data, 3);
    cmp("t5_count", 32'(wr_count), 10);

    // Reset from a terminal state
    step(1, 0, 0, 0); step(0, 1, 80, 1); step(0, 1, 84, 7);
    cmp("t6_pass", 32'(pass), 1);
    step(1, 1, 84, 7);
    cmp("t6_done", 32'(done), 0); cmp("t6_pass0", 32'(pass), 0);
    cmp("t6_count0", 32'(wr_count), 0);
    sel(0); cmp("t6_valid0", 32'(trace_valid), 0);
    step(0, 1, 80, 1);
    cmp("t6_count1", 32'(wr_count), 1);

    // Randomized stores
    step(1, 0, 0, 0);
    term_cycles = 0;
    for (int n = 0; n < 2000; n++) begin
      r  = ($urandom_range(0, 99) < 2) || (term_cycles > 4);
      mw = ($urandom_range(0, 99) < 55);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'd80;
        6, 7:             a = 32'd84;
        8:                a = 32'($urandom_range(76, 88));
        default:          a = $urandom;
      endcase
      d = ($urandom_range(0, 1) == 1) ? 32'd7 : 32'($urandom_range(0, 15));
      step(r, mw, a, d);
      term_cycles = (ms == M_RUN) ? 0 : term_cycles + 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
